blob_pixel_feeder: RTL and testbench

Producer side of the blob-counting pixel interface. On a start pulse, pops one RGB frame (IMG_COL×IMG_ROW pixels, raster order) from the SDRAM read FIFO, reduces each pixel to a 1-bit foreground flag, and streams it one bit per cycle to the blob counter under its `valid`/`request` handshake. When the counter reports done, the feeder latches the blob count for the display path and releases the counter.

---
 rtl/blob_pkg.sv | 27 ++
 rtl/blob_luma_threshold.sv | 26 ++
 rtl/blob_pixel_feeder.sv | 145 ++++++++++++++
 tb/tb_blob_pixel_feeder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/blob_pkg.sv
// Shared definitions for the blob-counting pixel path: frame geometry
// defaults, the feeder state type and the RGB-to-luma reduction.
package blob_pkg;

  localparam int DEF_IMG_COL = 800;
  localparam int DEF_IMG_ROW = 600;
  localparam int DEF_PIX_W   = 10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRIME     = 3'd1,
    STREAM    = 3'd2,
    WAIT_DONE = 3'd3,
    RELEASE   = 3'd4
  } feeder_state_e;

  // Y = (R + 2G + B) >> 2. Operands arrive zero-extended to 32 bits, so
  // the sum cannot overflow for any practical channel width.
  function automatic logic [31:0] luma(input logic [31:0] r,
                                       input logic [31:0] g,
                                       input logic [31:0] b);
    logic [31:0] sum;
    sum = r + (g << 1) + b;
    return sum >> 2;
  endfunction

endpackage

// File: rtl/blob_luma_threshold.sv
// Combinational reduction of one {R,G,B} pixel to a foreground flag.
module blob_luma_threshold
  import blob_pkg::*;
#(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int THRESH = 512,
  parameter bit INVERT = 1'b0
) (
  input  logic [3*PIX_W-1:0] rgb_i,
  output logic               fg_o
);

  localparam logic [PIX_W-1:0] THRESH_V = PIX_W'(THRESH);

  logic [PIX_W-1:0] r;
  logic [PIX_W-1:0] g;
  logic [PIX_W-1:0] b;
  logic [PIX_W-1:0] y;

  assign {r, g, b} = rgb_i;

  // The average of four channel-width terms always fits back into PIX_W.
  assign y    = PIX_W'(luma(32'(r), 32'(g), 32'(b)));
  assign fg_o = (y >= THRESH_V) ^ INVERT;

endmodule

// File: rtl/blob_pixel_feeder.sv
// Streams one RGB frame from the SDRAM read FIFO to the blob counter as a
// 1-bit foreground sequence, then latches the counter's result.
module blob_pixel_feeder
  import blob_pkg::*;
#(
  parameter int IMG_COL = DEF_IMG_COL,
  parameter int IMG_ROW = DEF_IMG_ROW,
  parameter int PIX_W   = DEF_PIX_W,
  parameter int THRESH  = 512,
  parameter bit INVERT  = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [3*PIX_W-1:0] i_rd_data,
  input  logic               i_rd_empty,
  output logic               o_rd_req,
  output logic               o_blob_valid,
  output logic               o_blob_seq,
  input  logic               i_blob_request,
  input  logic               i_blob_done,
  input  logic [7:0]         i_blob_count,
  output logic [7:0]         o_count,
  output logic               o_count_valid,
  output logic               o_busy,
  output logic               o_underrun
);

  localparam int              NPIX     = IMG_COL * IMG_ROW;
  localparam int              CW       = $clog2(NPIX + 1);
  localparam logic [CW-1:0]   LAST_IDX = CW'(NPIX - 1);

  feeder_state_e state_q, state_d;
  logic [CW-1:0] pix_cnt_q, pix_cnt_d;
  logic          valid_q, valid_d;
  logic          seq_q, seq_d;
  logic [7:0]    count_q, count_d;
  logic          count_valid_q, count_valid_d;
  logic          underrun_q, underrun_d;
  logic          fg;
  logic          rd_req;

  blob_luma_threshold #(
    .PIX_W  (PIX_W),
    .THRESH (THRESH),
    .INVERT (INVERT)
  ) u_luma (
    .rgb_i (i_rd_data),
    .fg_o  (fg)
  );

  // Next-state logic: frame sequencing, pixel accounting and FIFO pops.
  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    valid_d       = valid_q;
    seq_d         = 1'b0;
    count_d       = count_q;
    count_valid_d = count_valid_q;
    underrun_d    = underrun_q;
    rd_req        = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          pix_cnt_d     = '0;
          underrun_d    = 1'b0;
          count_valid_d = 1'b0;
          state_d       = PRIME;
        end
      end

      PRIME: begin
        if (!i_rd_empty) begin
          valid_d = 1'b1;
          state_d = STREAM;
        end
      end

      STREAM: begin
        if (i_blob_request) begin
          // A starved request still advances the index so the counter's
          // notion of raster position never drifts from ours.
          if (i_rd_empty) begin
            underrun_d = 1'b1;
          end else begin
            rd_req = 1'b1;
            seq_d  = fg;
          end
          pix_cnt_d = pix_cnt_q + 1'b1;
          if (pix_cnt_q == LAST_IDX) begin
            state_d = WAIT_DONE;
          end
        end
      end

      WAIT_DONE: begin
        if (i_blob_done) begin
          count_d       = i_blob_count;
          count_valid_d = 1'b1;
          valid_d       = 1'b0;
          state_d       = RELEASE;
        end
      end

      RELEASE: begin
        if (!i_blob_done) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts a frame without draining.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      pix_cnt_q     <= '0;
      valid_q       <= 1'b0;
      seq_q         <= 1'b0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      valid_q       <= valid_d;
      seq_q         <= seq_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      underrun_q    <= underrun_d;
    end
  end

  assign o_rd_req      = rd_req;
  assign o_blob_valid  = valid_q;
  assign o_blob_seq    = seq_q;
  assign o_count       = count_q;
  assign o_count_valid = count_valid_q;
  assign o_busy        = (state_q != IDLE);
  assign o_underrun    = underrun_q;

endmodule

// File: tb/tb_blob_pixel_feeder.sv
// Directed bench for blob_pixel_feeder on an 8x4 frame; a normal and an
// inverted instance share one FIFO model and one counter model.
module tb_blob_pixel_feeder;

  localparam int NPIX = 32;
  localparam int M_IDLE = 0, M_PRIME = 1, M_STREAM = 2, M_WAIT = 3, M_REL = 4;

  typedef struct {
    logic seq;
    logic seq_inv;
    int   idx;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [29:0] rd_data;
  logic        rd_empty;
  logic        blob_request;
  logic        blob_done;
  logic [7:0]  blob_count;
  logic        hole;

  logic        o_rd_req, o_blob_valid, o_blob_seq, o_count_valid, o_busy, o_underrun;
  logic [7:0]  o_count;
  logic        inv_rd_req, inv_blob_valid, inv_blob_seq, inv_count_valid, inv_busy, inv_underrun;
  logic [7:0]  inv_count;

  logic [29:0] fifo[$];
  sb_t         sb[$];

  int          m_state, m_cnt;
  logic        m_valid, m_underrun, m_cv;
  logic [7:0]  m_count;
  int          dut_pops;
  logic [31:0] obs_mask;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  blob_pixel_feeder #(
    .IMG_COL(8), .IMG_ROW(4), .PIX_W(10), .THRESH(512), .INVERT(1'b0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_rd_data(rd_data),
    .i_rd_empty(rd_empty), .o_rd_req(o_rd_req), .o_blob_valid(o_blob_valid),
    .o_blob_seq(o_blob_seq), .i_blob_request(blob_request), .i_blob_done(blob_done),
    .i_blob_count(blob_count), .o_count(o_count), .o_count_valid(o_count_valid),
    .o_busy(o_busy), .o_underrun(o_underrun)
  );

  blob_pixel_feeder #(
    .IMG_COL(8), .IMG_ROW(4), .PIX_W(10), .THRESH(512), .INVERT(1'b1)
  ) dut_inv (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_rd_data(rd_data),
    .i_rd_empty(rd_empty), .o_rd_req(inv_rd_req), .o_blob_valid(inv_blob_valid),
    .o_blob_seq(inv_blob_seq), .i_blob_request(blob_request), .i_blob_done(blob_done),
    .i_blob_count(blob_count), .o_count(inv_count), .o_count_valid(inv_count_valid),
    .o_busy(inv_busy), .o_underrun(inv_underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] px(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    return {r, g, b};
  endfunction

  function automatic logic fg_of(input logic [29:0] w);
    int r, g, b, y;
    r = int'(w[29:20]);
    g = int'(w[19:10]);
    b = int'(w[9:0]);
    y = (r + 2 * g + b) / 4;
    return (y >= 512);
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_cnt = 0; m_valid = 0; m_underrun = 0; m_cv = 0; m_count = 8'h00;
    sb.delete();
  endtask

  task automatic chk_outputs(input string ph);
    chk({ph, "_blob_valid"}, o_blob_valid, m_valid);
    chk({ph, "_busy"}, o_busy, (m_state != M_IDLE));
    chk({ph, "_underrun"}, o_underrun, m_underrun);
    chk({ph, "_count_valid"}, o_count_valid, m_cv);
    chk({ph, "_count"}, o_count, m_count);
    chk({ph, "_inv_blob_valid"}, inv_blob_valid, m_valid);
    chk({ph, "_inv_busy"}, inv_busy, (m_state != M_IDLE));
    chk({ph, "_inv_underrun"}, inv_underrun, m_underrun);
    chk({ph, "_inv_count_valid"}, inv_count_valid, m_cv);
    chk({ph, "_inv_count"}, inv_count, m_count);
  endtask

  // One clock: called at posedge+1 with inputs already chosen by the caller.
  task automatic step();
    sb_t  e;
    logic exp_req;
    rd_empty = (fifo.size() == 0) || hole;
    rd_data  = (fifo.size() != 0) ? fifo[0] : 30'd0;
    #1;
    exp_req = (m_state == M_STREAM) && blob_request && !rd_empty;
    chk("rd_req", o_rd_req, exp_req);
    chk("inv_rd_req", inv_rd_req, exp_req);
    if (o_rd_req) dut_pops++;
    e.seq = 1'b0; e.seq_inv = 1'b0; e.idx = -1;
    case (m_state)
      M_IDLE: if (start) begin m_cnt = 0; m_underrun = 0; m_cv = 0; m_state = M_PRIME; end
      M_PRIME: if (!rd_empty) begin m_valid = 1; m_state = M_STREAM; end
      M_STREAM: if (blob_request) begin
        e.idx = m_cnt;
        if (rd_empty) m_underrun = 1;
        else begin e.seq = fg_of(fifo[0]); e.seq_inv = !e.seq; end
        m_cnt++;
        if (m_cnt == NPIX) m_state = M_WAIT;
      end
      M_WAIT: if (blob_done) begin m_count = blob_count; m_cv = 1; m_valid = 0; m_state = M_REL; end
      M_REL: if (!blob_done) m_state = M_IDLE;
      default: ;
    endcase
    if (exp_req) void'(fifo.pop_front());
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("blob_seq", o_blob_seq, e.seq);
    chk("inv_blob_seq", inv_blob_seq, e.seq_inv);
    if (e.idx >= 0) obs_mask[e.idx] = o_blob_seq;
    chk_outputs("cyc");
  endtask

  task automatic chk_all_zero(input string ph);
    chk({ph, "_rd_req"}, o_rd_req, 0);
    chk({ph, "_blob_valid"}, o_blob_valid, 0);
    chk({ph, "_blob_seq"}, o_blob_seq, 0);
    chk({ph, "_count"}, o_count, 0);
    chk({ph, "_count_valid"}, o_count_valid, 0);
    chk({ph, "_busy"}, o_busy, 0);
    chk({ph, "_underrun"}, o_underrun, 0);
    chk({ph, "_inv_blob_seq"}, inv_blob_seq, 0);
    chk({ph, "_inv_busy"}, inv_busy, 0);
  endtask

  initial begin
    int holes;
    rst = 1'b1; start = 0; blob_request = 0; blob_done = 0; blob_count = 8'h00; hole = 0;
    rd_data = '0; rd_empty = 1'b1; dut_pops = 0; obs_mask = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    step(); step();

    // Start with the FIFO empty: the feeder must sit in PRIME.
    start = 1; step(); start = 0;
    repeat (3) step();

    // Frame A: white at 9, 10, 17; request gap and an early done pulse.
    for (int k = 0; k < NPIX; k++)
      fifo.push_back((k == 9 || k == 10 || k == 17) ? px(10'd1023, 10'd1023, 10'd1023) : px(0, 0, 0));
    dut_pops = 0; obs_mask = '0;
    step();
    for (int i = 0; i < 200 && m_state == M_STREAM; i++) begin
      blob_request = !(i == 5 || i == 6);
      blob_done    = (i == 8);
      blob_count   = 8'h77;
      step();
    end
    blob_request = 0; blob_done = 0;
    chk("A_pops", dut_pops, NPIX);
    chk("A_mask", obs_mask, 32'h0002_0600);
    chk("A_underrun", o_underrun, 0);

    // Start while waiting for the counter is ignored; then done with 0x05.
    start = 1; step(); start = 0;
    step(); step();
    blob_done = 1; blob_count = 8'h05; step();
    chk("A_count", o_count, 8'h05);
    chk("A_count_valid", o_count_valid, 1);
    chk("A_blob_valid_fall", o_blob_valid, 0);
    step();
    blob_done = 0; step();
    chk("A_idle", o_busy, 0);

    // Frame B: luma edges at 0..2 and a 3-cycle FIFO hole at pixel 12.
    fifo.push_back(px(10'd512, 10'd512, 10'd512));
    fifo.push_back(px(10'd511, 10'd512, 10'd512));
    fifo.push_back(px(10'd1023, 10'd0, 10'd0));
    for (int k = 3; k < NPIX; k++)
      fifo.push_back((k % 3 == 0) ? px(10'd1023, 10'd900, 10'd700) : px(10'd100, 10'd50, 10'd0));
    dut_pops = 0; obs_mask = '0; holes = 0;
    start = 1; step(); start = 0;
    blob_request = 1;
    step();
    for (int i = 0; i < 200 && m_state == M_STREAM; i++) begin
      hole = (m_state == M_STREAM) && (m_cnt >= 12) && (holes < 3);
      step();
      if (hole) holes++;
    end
    hole = 0; blob_request = 0;
    chk("B_pops", dut_pops, NPIX - 3);
    chk("B_leftover", fifo.size(), 3);
    chk("B_edges", obs_mask[2:0], 3'b001);
    chk("B_hole_bits", obs_mask[14:12], 3'b000);
    chk("B_underrun", o_underrun, 1);
    blob_done = 1; blob_count = 8'h09; step();
    blob_done = 0; step();
    chk("B_count", o_count, 8'h09);

    // Frame C: reset while streaming clears outputs without a clock edge.
    fifo.delete();
    for (int k = 0; k < NPIX; k++) fifo.push_back(px(10'd1023, 10'd1023, 10'd1023));
    start = 1; step(); start = 0;
    blob_request = 1;
    repeat (8) step();
    rst = 1'b1;
    #1;
    chk_all_zero("midreset");
    model_reset();
    blob_request = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
